// File: rtl/spi_ram_pkg.sv
// Shared command encodings and read-latency limits for the SPI burst RAM.
package spi_ram_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

endpackage

// File: rtl/spi_ram_mem.sv
// MEM_DEPTH x WORD_W storage: one write port, one registered read port,
// optional extra output register for the two-cycle read path.
module spi_ram_mem #(
    parameter int WORD_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int OUT_REG   = 0
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WORD_W-1:0] r_out;
            always_ff @(posedge clk) r_out <= r_rdata;
            assign o_rdata = r_out;
        end else begin : g_no_out_reg
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/spi_ram_burst.sv
// SPI command-frame RAM: decodes 2-bit commands into pointer/memory ops,
// with pipelined reads, optional pointer auto-increment and range errors.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int READ_LAT  = 1,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W+1:0] din,
    input  logic              rx_valid,
    output logic [WORD_W-1:0] dout,
    output logic              tx_valid,
    output logic              err
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int LAT    = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT_MIN;
    localparam logic [WORD_W:0]   DEPTH = (WORD_W+1)'(MEM_DEPTH);
    localparam logic [WORD_W-1:0] LAST  = WORD_W'(MEM_DEPTH - 1);

    logic [WORD_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [LAT-1:0]    r_vld_pipe, r_oor_pipe;

    cmd_t              w_cmd;
    logic [WORD_W-1:0] w_pay, w_rdata, w_wr_nxt, w_rd_nxt;
    logic              w_wr_go, w_rd_go, w_wr_ok, w_rd_ok, w_out_vld, w_out_oor;

    assign w_cmd     = din[WORD_W+1:WORD_W];
    assign w_pay     = din[WORD_W-1:0];
    assign w_wr_go   = rx_valid && !rst && (w_cmd == CMD_WR_DATA);
    assign w_rd_go   = rx_valid && !rst && (w_cmd == CMD_RD_DATA);
    assign w_wr_ok   = {1'b0, r_wr_ptr} < DEPTH;
    assign w_rd_ok   = {1'b0, r_rd_ptr} < DEPTH;
    assign w_wr_nxt  = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt  = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
    assign w_out_vld = r_vld_pipe[LAT-1];
    assign w_out_oor = r_oor_pipe[LAT-1];

    // Out-of-range reads still flow down the pipe so they produce a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_vld_pipe <= '0;
            r_oor_pipe <= '0;
            dout       <= '0;
            tx_valid   <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_vld_pipe <= (r_vld_pipe << 1) | LAT'(w_rd_go);
            r_oor_pipe <= (r_oor_pipe << 1) | LAT'(w_rd_go && !w_rd_ok);
            tx_valid   <= w_out_vld;
            if (w_out_vld) dout <= w_out_oor ? '0 : w_rdata;
            err <= (w_wr_go && !w_wr_ok) || (w_out_vld && w_out_oor);
            if (rx_valid) begin
                case (w_cmd)
                    CMD_WR_ADDR: r_wr_ptr <= w_pay;
                    CMD_WR_DATA: if (w_wr_ok && AUTO_INC != 0) r_wr_ptr <= w_wr_nxt;
                    CMD_RD_ADDR: r_rd_ptr <= w_pay;
                    default:     if (w_rd_ok && AUTO_INC != 0) r_rd_ptr <= w_rd_nxt;
                endcase
            end
        end
    end

    spi_ram_mem #(
        .WORD_W   (WORD_W),
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W   (ADDR_W),
        .OUT_REG  ((LAT == 2) ? 1 : 0)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_wr_go && w_wr_ok),
        .i_waddr(r_wr_ptr[ADDR_W-1:0]),
        .i_wdata(w_pay),
        .i_re   (w_rd_go && w_rd_ok),
        .i_raddr(r_rd_ptr[ADDR_W-1:0]),
        .o_rdata(w_rdata)
    );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: table of per-cycle vectors for the default build, plus
// hand sequences for a 200-word build and a two-cycle read build.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;

    logic [7:0] a_dout, b_dout, c_dout;
    logic       a_tx, b_tx, c_tx, a_err, b_err, c_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_ram_burst u_a (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(a_dout), .tx_valid(a_tx), .err(a_err)
    );

    spi_ram_burst #(.MEM_DEPTH(200)) u_b (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(b_dout), .tx_valid(b_tx), .err(b_err)
    );

    spi_ram_burst #(.READ_LAT(2)) u_c (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(c_dout), .tx_valid(c_tx), .err(c_err)
    );

    typedef struct {
        logic [9:0] din;
        logic       rxv;
        logic       tx;
        logic [7:0] dout;
        logic       chk_d;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] c, input logic [7:0] p, input logic v,
                       input logic tx, input logic [7:0] d, input logic cd);
        vec_t e;
        e.din = {c, p}; e.rxv = v; e.tx = tx; e.dout = d; e.chk_d = cd;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1ns after the following rising edge.
    task automatic step(input logic [9:0] d, input logic v);
        @(negedge clk);
        din = d;
        rx_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Burst write then burst read
        add(2'b00, 8'h10, 1, 0, 8'h00, 0);
        add(2'b01, 8'hA5, 1, 0, 8'h00, 0);
        add(2'b01, 8'h5A, 1, 0, 8'h00, 0);
        add(2'b10, 8'h10, 1, 0, 8'h00, 0);
        add(2'b11, 8'h00, 1, 0, 8'h00, 0);
        add(2'b11, 8'h00, 1, 1, 8'hA5, 1);
        add(2'b00, 8'h00, 0, 1, 8'h5A, 1);
        add(2'b00, 8'h00, 0, 0, 8'h5A, 1);
        // Wrap FF -> 00 on both pointers
        add(2'b00, 8'hFF, 1, 0, 8'h5A, 1);
        add(2'b01, 8'h11, 1, 0, 8'h5A, 1);
        add(2'b01, 8'h22, 1, 0, 8'h5A, 1);
        add(2'b10, 8'hFF, 1, 0, 8'h5A, 1);
        add(2'b11, 8'h00, 1, 0, 8'h5A, 1);
        add(2'b11, 8'h00, 1, 1, 8'h11, 1);
        add(2'b10, 8'h10, 1, 1, 8'h22, 1);
        add(2'b11, 8'h00, 1, 0, 8'h22, 1);
        add(2'b10, 8'h00, 1, 1, 8'hA5, 1);
        add(2'b11, 8'h00, 1, 0, 8'hA5, 1);
        add(2'b00, 8'h00, 0, 1, 8'h22, 1);
        add(2'b00, 8'h00, 0, 0, 8'h22, 1);
        // rx_valid low must suppress the write and pointer step
        add(2'b00, 8'h30, 1, 0, 8'h22, 1);
        add(2'b01, 8'h44, 1, 0, 8'h22, 1);
        add(2'b01, 8'h77, 0, 0, 8'h22, 1);
        add(2'b01, 8'h55, 1, 0, 8'h22, 1);
        add(2'b10, 8'h30, 1, 0, 8'h22, 1);
        add(2'b11, 8'h00, 1, 0, 8'h22, 1);
        add(2'b11, 8'h00, 1, 1, 8'h44, 1);
        add(2'b00, 8'h00, 0, 1, 8'h55, 1);
        add(2'b00, 8'h00, 0, 0, 8'h55, 1);

        // Reset with a live command on the bus
        rst = 1'b1; din = 10'h1FF; rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_dout", a_dout, 8'h00); chk("rst a_tx", a_tx, 0); chk("rst a_err", a_err, 0);
        chk("rst b_dout", b_dout, 8'h00); chk("rst b_tx", b_tx, 0); chk("rst b_err", b_err, 0);
        chk("rst c_dout", c_dout, 8'h00); chk("rst c_tx", c_tx, 0); chk("rst c_err", c_err, 0);
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        step({2'b11, 8'h00}, 1); chk("post-rst rd launch tx", a_tx, 0);
        step(10'h000, 0);        chk("post-rst rd tx", a_tx, 1);
        step(10'h000, 0);        chk("post-rst rd tx drop", a_tx, 0);
        step(10'h000, 0);

        foreach (vq[i]) begin
            step(vq[i].din, vq[i].rxv);
            chk($sformatf("row%0d tx", i), a_tx, vq[i].tx);
            chk($sformatf("row%0d err", i), a_err, 0);
            if (vq[i].chk_d) chk($sformatf("row%0d dout", i), a_dout, vq[i].dout);
        end

        // 200-word build: out-of-range write and read
        step({2'b00, 8'hC8}, 1); chk("oor wa err", b_err, 0);
        step({2'b01, 8'h33}, 1); chk("oor wr err", b_err, 1); chk("oor wr tx", b_tx, 0);
        step(10'h000, 0);        chk("oor wr err drop", b_err, 0);
        step({2'b01, 8'h44}, 1); chk("oor ptr held err", b_err, 1);
        step({2'b10, 8'hC8}, 1); chk("oor ra err", b_err, 0);
        step({2'b11, 8'h00}, 1); chk("oor rd launch tx", b_tx, 0); chk("oor rd launch err", b_err, 0);
        step(10'h000, 0);
        chk("oor rd tx", b_tx, 1); chk("oor rd dout", b_dout, 8'h00); chk("oor rd err", b_err, 1);
        step(10'h000, 0);        chk("oor rd tx drop", b_tx, 0); chk("oor rd err drop", b_err, 0);

        // Two-cycle read build: latency check, then reset mid-read
        step({2'b00, 8'h05}, 1);
        step({2'b01, 8'hC3}, 1);
        step({2'b10, 8'h05}, 1);
        step({2'b11, 8'h00}, 1); chk("lat2 tx e0", c_tx, 0);
        step(10'h000, 0);        chk("lat2 tx e1", c_tx, 0);
        step(10'h000, 0);        chk("lat2 tx e2", c_tx, 1); chk("lat2 dout", c_dout, 8'hC3);
        step(10'h000, 0);        chk("lat2 tx e3", c_tx, 0);
        step({2'b10, 8'h05}, 1);
        step({2'b11, 8'h00}, 1);
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; din = 10'h000;
        #1;
        chk("midrst c_tx", c_tx, 0); chk("midrst c_dout", c_dout, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst hold c_tx", c_tx, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(10'h000, 0);
            chk($sformatf("post-midrst c_tx %0d", k), c_tx, 0);
            chk($sformatf("post-midrst c_dout %0d", k), c_dout, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
